lzc_normalizer: RTL
===================

// Module: lzc_normalizer
// PURPOSE
//  Pipelined, parametrised leading-one detector and normaliser for the twos_to_float datapath.
//  - Takes an unsigned magnitude (sign already stripped upstream).
//  - Returns the saturated leading-zero count and the magnitude left-shifted by that count.
//  - Carries zero/saturation flags.
//  - valid/ready elastic handshake on both sides; sits between magnitude extraction and exponent/rounding logic.
// PARAMETERS
//  IN_W     11                  magnitude width in bits (>=2)
//  SAT_CNT  7                   maximum shift reported/applied; counts above clamp here (0 < SAT_CNT <= IN_W-1)
//  CNT_W    $clog2(IN_W+1)      width of shift field (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      in_mag valid this cycle
//  in_ready   out  1      block can accept in_mag this cycle
//  in_mag     in   IN_W   unsigned magnitude
//  out_valid  out  1      result fields valid
//  out_ready  in   1      downstream accepts result this cycle
//  out_shift  out  CNT_W  min(leading zeros of in_mag, SAT_CNT)
//  out_norm   out  IN_W   in_mag << out_shift (zero-filled from LSB)
//  out_zero   out  1      in_mag was all zeros
//  out_sat    out  1      leading-zero count > SAT_CNT, or in_mag == 0
// BEHAVIOUR
//  Reset
//   - One clock, synchronous active-low reset: rst_n sampled on rising clk only.
//   - rst_n=0 clears s1_valid, s2_valid, out_shift, out_norm, out_zero and out_sat to 0.
//   - Items in flight are dropped, not flushed.
//   - in_ready=1 in the first cycle after reset deasserts.
//  Pipeline
//   - 2 register stages.
//   - S1: registers in_mag and the leading-zero count from the lead_one_detect sub-module.
//   - S2: applies the clamp and barrel shift, registers the outputs.
//   - Latency: 2 cycles from input handshake to out_valid when out_ready is held high.
//   - Throughput: 1 item per cycle.
//  Handshake
//   - Transfer on X_valid && X_ready.
//   - in_ready = !s1_valid || s1 advances this cycle; s1 advances when !s2_valid || out_ready (combinational, no bubble).
//   - While out_valid && !out_ready, all out_* fields hold stable; S1 holds if also full.
//   - out_valid never drops without a handshake.
//   - in_valid with in_ready=0: the input is not captured; the source must hold its value.
//  Arithmetic
//   - lz = number of zero bits above the highest set bit (MSB = bit IN_W-1).
//   - shift = (lz > SAT_CNT) ? SAT_CNT : lz; out_sat = (lz > SAT_CNT).
//   - in_mag==0: out_zero=1, out_sat=1, out_shift=SAT_CNT, out_norm=0.
//   - out_norm is always exactly IN_W bits; bits shifted past the MSB are impossible, since shift <= lz.
//  Boundaries
//   - Full pipe with out_ready=0: in_ready=0, no data overwritten.
//   - Same-cycle pop from S2 and push into S1: both occur, no stall.
//   - rst_n=0 mid-stall: outputs clear on that edge; the stalled item is lost.
//  Not in this block
//   - X on in_mag while in_valid=0 must not propagate to out_* (flops enabled only on handshake).
// STRUCTURE
//  Shared header twos_float_defs.vh holds:
//   - default IN_W and SAT_CNT
//   - the CNT_W derivation macro, shared with the exponent-bias logic
//  Sub-module lead_one_detect #(IN_W):
//   - combinational, input [IN_W-1:0], outputs lz[CNT_W-1:0] and all_zero
//   - loop-based priority scan from MSB
//  Top level holds the two stage registers, the clamp, the shifter and the handshake logic.
// TESTING (IN_W=11, SAT_CNT=7)
//  1. in_mag=11'h400, out_ready=1 -> 2 cycles later: shift=0, norm=11'h400, zero=0, sat=0.
//  2. in_mag=11'h020 -> shift=5, norm=11'h400; in_mag=11'h0FF -> shift=3, norm=11'h7F8.
//  3. in_mag=11'h001 -> shift=7, norm=11'h080, sat=1; in_mag=0 -> shift=7, norm=0, zero=1, sat=1.
//  4. Stream 8 back-to-back values, out_ready=0 for cycles 3-6:
//     - in_ready falls once both stages are full
//     - out_* stable during the stall
//     - all 8 results emerge in order, none duplicated or dropped.
//  5. Pull rst_n=0 for 1 cycle with 2 items in flight and out_ready=0 -> next cycle out_valid=0, outputs 0, in_ready=1.
//  6. Random in_mag/in_valid/out_ready for 10k cycles vs reference model (clamped clz and shift).
//     Check ordering and zero loss, and sweep IN_W in {4, 11, 32}, SAT_CNT in {1, IN_W-1}.

Source files
------------

// File: rtl/lzc_normalizer_pkg.sv
// Shared defaults and width derivation for the twos_to_float normaliser path.
// The exponent-bias logic derives its shift-field width from the same helper.
package lzc_normalizer_pkg;

    localparam int DEF_IN_W    = 11;
    localparam int DEF_SAT_CNT = 7;

    // Width needed to hold a count of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzc_normalizer_lead_one_detect.sv
// Combinational leading-one detector: number of zeros above the highest set bit.
// An all-zero input reports IN_W.
module lead_one_detect
    import lzc_normalizer_pkg::*;
#(
    parameter int  IN_W  = DEF_IN_W,
    localparam int CNT_W = cnt_width(IN_W)
) (
    input  logic [IN_W-1:0]  mag,
    output logic [CNT_W-1:0] lz,
    output logic             all_zero
);

    // Scan upward so the highest set bit is the last one to write lz.
    always_comb begin
        lz = CNT_W'(IN_W);
        for (int i = 0; i < IN_W; i++) begin
            if (mag[i]) begin
                lz = CNT_W'(IN_W - 1 - i);
            end
        end
    end

    assign all_zero = ~|mag;

endmodule

// File: rtl/lzc_normalizer.sv
// Two-stage elastic leading-zero count and normalise stage.
// S1 holds the magnitude and its raw count; S2 holds the clamped, shifted result.
module lzc_normalizer
    import lzc_normalizer_pkg::*;
#(
    parameter int  IN_W    = DEF_IN_W,
    parameter int  SAT_CNT = DEF_SAT_CNT,
    localparam int CNT_W   = cnt_width(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_shift,
    output logic [IN_W-1:0]  out_norm,
    output logic             out_zero,
    output logic             out_sat
);

    logic             s1_valid;
    logic [IN_W-1:0]  s1_mag;
    logic [CNT_W-1:0] s1_lz;
    logic             s1_zero;
    logic             s2_valid;

    logic [CNT_W-1:0] lz_c;
    logic             zero_c;
    logic             s1_adv;
    logic             sat_c;
    logic [CNT_W-1:0] shift_c;

    lead_one_detect #(.IN_W(IN_W)) u_lod (
        .mag      (in_mag),
        .lz       (lz_c),
        .all_zero (zero_c)
    );

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;

    // shift never exceeds lz, so no set bit is pushed past the MSB.
    assign sat_c   = s1_lz > CNT_W'(SAT_CNT);
    assign shift_c = sat_c ? CNT_W'(SAT_CNT) : s1_lz;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_lz    <= '0;
            s1_zero  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag  <= in_mag;
                s1_lz   <= lz_c;
                s1_zero <= zero_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            out_shift <= '0;
            out_norm  <= '0;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_shift <= shift_c;
                out_norm  <= s1_mag << shift_c;
                out_zero  <= s1_zero;
                out_sat   <= sat_c;
            end
        end
    end

endmodule
